// File: rtl/brownout_ctrl_if.sv
// ----------------------------------------------------------------------------
// brownout_ctrl_if
//   Bundles the signals between brownout_ctrl, its software control and the
//   analog brownout detector.
//
//   slave  modport : the controller (brownout_ctrl)
//   master modport : whoever drives the controller (software regs + detector)
//
//   Software side : en, cfg_otrip, cfg_vtrip, cfg_wr, irq_clr, cnt_clr (in)
//                   state, evt_cnt, irq, vunder_flag, sys_rst (out)
//   Detector side : bo_out, bo_vunder (in, asynchronous)
//                   bo_ena, bo_otrip, bo_vtrip (out)
// ----------------------------------------------------------------------------
interface brownout_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             en;
   logic [2:0]       cfg_otrip;
   logic [2:0]       cfg_vtrip;
   logic             cfg_wr;
   logic             irq_clr;
   logic             cnt_clr;
   logic             bo_out;
   logic             bo_vunder;
   logic             bo_ena;
   logic [2:0]       bo_otrip;
   logic [2:0]       bo_vtrip;
   logic             sys_rst;
   logic [2:0]       state;
   logic [CNT_W-1:0] evt_cnt;
   logic             irq;
   logic             vunder_flag;

   modport slave (
      input  en, cfg_otrip, cfg_vtrip, cfg_wr, irq_clr, cnt_clr, bo_out, bo_vunder,
      output bo_ena, bo_otrip, bo_vtrip, sys_rst, state, evt_cnt, irq, vunder_flag
   );

   modport master (
      output en, cfg_otrip, cfg_vtrip, cfg_wr, irq_clr, cnt_clr, bo_out, bo_vunder,
      input  bo_ena, bo_otrip, bo_vtrip, sys_rst, state, evt_cnt, irq, vunder_flag
   );
endinterface

// File: rtl/brownout_ctrl.sv
// ----------------------------------------------------------------------------
// brownout_ctrl
//   Digital controller for the brownout detector (dvdd side). Sequences the
//   detector enable and settling time, glitch-filters the brownout output,
//   holds a system reset request after the supply recovers, counts brownout
//   events (saturating) and raises a sticky interrupt.
//
//   Ports:
//     clk  - dvdd clock
//     rst  - asynchronous, active-high reset
//     bus  - brownout_ctrl_if.slave (software control/status + detector I/O)
//
//   Optional feature macro: BROWNOUT_CTRL_VUNDER_EN
//     Defined   : bo_vunder is synchronized and filtered into a sticky
//                 vunder_flag (cleared by irq_clr); its rising edge also
//                 sets irq.
//     Undefined : bo_vunder is ignored and vunder_flag is tied to 0.
//
//   State codes: OFF=0, SETTLE=1, MONITOR=2, BROWNOUT=3, HOLD=4.
// ----------------------------------------------------------------------------
module brownout_ctrl #(
   parameter int SETTLE_CYCLES = 1000,
   parameter int FILT_CYCLES   = 4,
   parameter int HOLD_CYCLES   = 256,
   parameter int CNT_W         = 8
) (
   input  logic            clk,
   input  logic            rst,
   brownout_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_SETTLE   = 3'd1,
      ST_MONITOR  = 3'd2,
      ST_BROWNOUT = 3'd3,
      ST_HOLD     = 3'd4
   } state_t;

   localparam int TMR_MAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int FILT_W  = $clog2(FILT_CYCLES + 1);

   localparam logic [TMR_W-1:0]  SETTLE_LD = TMR_W'(SETTLE_CYCLES);
   localparam logic [TMR_W-1:0]  HOLD_LD   = TMR_W'(HOLD_CYCLES);
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_CYCLES - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_t            state_q;
   logic [TMR_W-1:0]  timer_q;
   logic [FILT_W-1:0] filt_q;
   logic              bo_ena_q;
   logic              sys_rst_q;
   logic [2:0]        otrip_q;
   logic [2:0]        vtrip_q;
   logic [CNT_W-1:0]  evt_q;
   logic              irq_q;
   logic              bo_fire;
   logic              vun_irq;

   // ---- synchronizer stage: bo_out -> out_p0 -> out_s ----
   logic out_p0;
   logic out_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_p0 <= 1'b0;
         out_s  <= 1'b0;
      end else begin
         out_p0 <= bus.bo_out;
         out_s  <= out_p0;
      end
   end

   // A brownout is declared on the edge where the filter completes. A config
   // write in the same cycle wins: the detector is being retrimmed, so its
   // output is not trusted until it has settled again.
   assign bo_fire = bus.en && !bus.cfg_wr && (state_q == ST_MONITOR) &&
                    out_s && (filt_q == FILT_LAST);

   // ---- control FSM ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_OFF;
         timer_q   <= '0;
         filt_q    <= '0;
         bo_ena_q  <= 1'b0;
         sys_rst_q <= 1'b0;
         otrip_q   <= 3'b111;
         vtrip_q   <= 3'b111;
      end else begin
         if (bus.cfg_wr) begin
            otrip_q <= bus.cfg_otrip;
            vtrip_q <= bus.cfg_vtrip;
         end

         if (!bus.en) begin
            state_q   <= ST_OFF;
            timer_q   <= '0;
            filt_q    <= '0;
            bo_ena_q  <= 1'b0;
            sys_rst_q <= 1'b0;
         end else begin
            case (state_q)
               ST_OFF: begin
                  state_q  <= ST_SETTLE;
                  timer_q  <= SETTLE_LD;
                  bo_ena_q <= 1'b1;
               end

               // Leaves on the edge where the timer would hit 0, so the state
               // is visible for exactly SETTLE_CYCLES cycles.
               ST_SETTLE: begin
                  if (bus.cfg_wr) begin
                     timer_q <= SETTLE_LD;
                  end else if (timer_q < TMR_W'(2)) begin
                     state_q <= ST_MONITOR;
                     timer_q <= '0;
                     filt_q  <= '0;
                  end else begin
                     timer_q <= timer_q - TMR_W'(1);
                  end
               end

               ST_MONITOR: begin
                  if (bus.cfg_wr) begin
                     state_q <= ST_SETTLE;
                     timer_q <= SETTLE_LD;
                     filt_q  <= '0;
                  end else if (bo_fire) begin
                     state_q   <= ST_BROWNOUT;
                     sys_rst_q <= 1'b1;
                     filt_q    <= '0;
                  end else if (out_s) begin
                     filt_q <= filt_q + FILT_W'(1);
                  end else begin
                     filt_q <= '0;
                  end
               end

               ST_BROWNOUT: begin
                  if (!out_s) begin
                     state_q <= ST_HOLD;
                     timer_q <= HOLD_LD;
                  end
               end

               // A relapse during HOLD is the same brownout, not a new event.
               ST_HOLD: begin
                  if (out_s) begin
                     state_q <= ST_BROWNOUT;
                     timer_q <= '0;
                  end else if (timer_q < TMR_W'(2)) begin
                     state_q   <= ST_MONITOR;
                     sys_rst_q <= 1'b0;
                     timer_q   <= '0;
                     filt_q    <= '0;
                  end else begin
                     timer_q <= timer_q - TMR_W'(1);
                  end
               end

               default: begin
                  state_q   <= ST_OFF;
                  timer_q   <= '0;
                  filt_q    <= '0;
                  bo_ena_q  <= 1'b0;
                  sys_rst_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // ---- event counter and sticky interrupt ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_q <= '0;
         irq_q <= 1'b0;
      end else begin
         if (bus.cnt_clr) begin
            evt_q <= bo_fire ? CNT_W'(1) : '0;
         end else if (bo_fire) begin
            evt_q <= sat_inc(evt_q);
         end
         irq_q <= bo_fire | vun_irq | (irq_q & ~bus.irq_clr);
      end
   end

`ifdef BROWNOUT_CTRL_VUNDER_EN
   // ---- vunder synchronizer stage and filter ----
   logic              vun_p0;
   logic              vun_s;
   logic [FILT_W-1:0] vfilt_q;
   logic              vflag_q;
   logic              vun_mon;
   logic              vun_fire;

   assign vun_mon  = bus.en && ((state_q == ST_MONITOR) || (state_q == ST_BROWNOUT) ||
                                (state_q == ST_HOLD));
   assign vun_fire = vun_mon && vun_s && (vfilt_q == FILT_LAST);
   assign vun_irq  = vun_fire && !vflag_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vun_p0  <= 1'b0;
         vun_s   <= 1'b0;
         vfilt_q <= '0;
         vflag_q <= 1'b0;
      end else begin
         vun_p0 <= bus.bo_vunder;
         vun_s  <= vun_p0;
         // Filter saturates at its last count so a steady vunder keeps the
         // flag asserted against irq_clr.
         if (!vun_mon || !vun_s) begin
            vfilt_q <= '0;
         end else if (vfilt_q != FILT_LAST) begin
            vfilt_q <= vfilt_q + FILT_W'(1);
         end
         vflag_q <= vun_fire | (vflag_q & ~bus.irq_clr);
      end
   end

   assign bus.vunder_flag = vflag_q;
`else
   assign vun_irq         = 1'b0;
   assign bus.vunder_flag = 1'b0;
`endif

   assign bus.bo_ena   = bo_ena_q;
   assign bus.bo_otrip = otrip_q;
   assign bus.bo_vtrip = vtrip_q;
   assign bus.sys_rst  = sys_rst_q;
   assign bus.state    = state_q;
   assign bus.evt_cnt  = evt_q;
   assign bus.irq      = irq_q;

endmodule

// File: tb/tb_brownout_ctrl.sv
// ----------------------------------------------------------------------------
// tb_brownout_ctrl
//   Self-checking bench for brownout_ctrl with SETTLE_CYCLES=10,
//   FILT_CYCLES=3, HOLD_CYCLES=8, CNT_W=8. A table of per-step stimulus and
//   expected outputs drives the main scenarios; expected records go through
//   a queue and are compared when the outputs are sampled. Hand-written
//   sequences cover counter clear/saturation, asynchronous reset and the
//   optional vunder flag.
// ----------------------------------------------------------------------------
module tb_brownout_ctrl;

   localparam logic [2:0] S_OFF = 3'd0, S_SET = 3'd1, S_MON = 3'd2, S_BO = 3'd3, S_HLD = 3'd4;
`ifdef BROWNOUT_CTRL_VUNDER_EN
   localparam logic VUN_EN = 1'b1;
`else
   localparam logic VUN_EN = 1'b0;
`endif

   typedef struct {
      logic [2:0] st;
      logic       ena;
      logic       srst;
      logic [7:0] cnt;
      logic       irq;
      logic [2:0] ot;
      logic [2:0] vt;
      logic       vf;
   } exp_t;

   typedef struct {
      int         n;
      logic       en;
      logic       bo;
      logic       wr;
      logic       ic;
      logic       cc;
      logic [2:0] cot;
      logic [2:0] cvt;
      exp_t       e;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;
   exp_t exp_q[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   brownout_ctrl_if #(.CNT_W(8)) bus ();

   brownout_ctrl #(
      .SETTLE_CYCLES(10),
      .FILT_CYCLES  (3),
      .HOLD_CYCLES  (8),
      .CNT_W        (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic exp_t mk_e(logic [2:0] st, logic ena, logic srst, logic [7:0] cnt,
                                 logic irq, logic [2:0] ot, logic [2:0] vt);
      exp_t e;
      e.st = st; e.ena = ena; e.srst = srst; e.cnt = cnt; e.irq = irq;
      e.ot = ot; e.vt = vt; e.vf = 1'b0;
      return e;
   endfunction

   function automatic vec_t mk(int n, logic en, logic bo, logic wr, logic ic, logic cc,
                               logic [2:0] cot, logic [2:0] cvt, exp_t e);
      vec_t v;
      v.n = n; v.en = en; v.bo = bo; v.wr = wr; v.ic = ic; v.cc = cc;
      v.cot = cot; v.cvt = cvt; v.e = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic sb_check(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_total++;
         $display("FAIL %s: scoreboard empty, got nothing, expected a record", tag);
         return;
      end
      e = exp_q.pop_front();
      chk({tag, ".state"},   32'(bus.state),       32'(e.st));
      chk({tag, ".bo_ena"},  32'(bus.bo_ena),      32'(e.ena));
      chk({tag, ".sys_rst"}, 32'(bus.sys_rst),     32'(e.srst));
      chk({tag, ".evt_cnt"}, 32'(bus.evt_cnt),     32'(e.cnt));
      chk({tag, ".irq"},     32'(bus.irq),         32'(e.irq));
      chk({tag, ".otrip"},   32'(bus.bo_otrip),    32'(e.ot));
      chk({tag, ".vtrip"},   32'(bus.bo_vtrip),    32'(e.vt));
      chk({tag, ".vflag"},   32'(bus.vunder_flag), 32'(e.vf));
   endtask

   task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
      int k = 0;
      while (bus.state !== tgt && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, 32'(bus.state), 32'(tgt));
   endtask

   // One complete brownout from MONITOR back to MONITOR (16 cycles).
   // clr_at_decl asserts cnt_clr on the edge that declares the brownout.
   task automatic bo_event(input logic clr_at_decl);
      bus.bo_out = 1'b1;
      repeat (4) @(negedge clk);
      bus.cnt_clr = clr_at_decl;
      @(negedge clk);
      bus.cnt_clr = 1'b0;
      bus.bo_out  = 1'b0;
      chk("event.state_bo", 32'(bus.state), 32'(S_BO));
      repeat (11) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.en = 1'b0; bus.cfg_otrip = 3'd0; bus.cfg_vtrip = 3'd0; bus.cfg_wr = 1'b0;
      bus.irq_clr = 1'b0; bus.cnt_clr = 1'b0; bus.bo_out = 1'b0; bus.bo_vunder = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      exp_q.push_back(mk_e(S_OFF, 0, 0, 0, 0, 3'd7, 3'd7));
      sb_check("reset");
      rst = 1'b0;

      //            n  en bo wr ic cc cot     cvt        st     ena srst cnt irq ot     vt
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_SET, 1, 0, 0, 0, 3'd7, 3'd7)));
      tbl.push_back(mk(9, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_SET, 1, 0, 0, 0, 3'd7, 3'd7)));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_MON, 1, 0, 0, 0, 3'd7, 3'd7)));
      // short glitch is filtered
      tbl.push_back(mk(2, 1, 1, 0, 0, 0, 3'd0, 3'd0, mk_e(S_MON, 1, 0, 0, 0, 3'd7, 3'd7)));
      tbl.push_back(mk(6, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_MON, 1, 0, 0, 0, 3'd7, 3'd7)));
      // sustained high: brownout 5 edges after rising
      tbl.push_back(mk(4, 1, 1, 0, 0, 0, 3'd0, 3'd0, mk_e(S_MON, 1, 0, 0, 0, 3'd7, 3'd7)));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 3'd0, 3'd0, mk_e(S_BO,  1, 1, 1, 1, 3'd7, 3'd7)));
      // drop -> HOLD, re-raise during HOLD -> BROWNOUT without new event
      tbl.push_back(mk(2, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_BO,  1, 1, 1, 1, 3'd7, 3'd7)));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_HLD, 1, 1, 1, 1, 3'd7, 3'd7)));
      tbl.push_back(mk(2, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_HLD, 1, 1, 1, 1, 3'd7, 3'd7)));
      tbl.push_back(mk(2, 1, 1, 0, 0, 0, 3'd0, 3'd0, mk_e(S_HLD, 1, 1, 1, 1, 3'd7, 3'd7)));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 3'd0, 3'd0, mk_e(S_BO,  1, 1, 1, 1, 3'd7, 3'd7)));
      // drop again: full 8-cycle HOLD then MONITOR
      tbl.push_back(mk(2, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_BO,  1, 1, 1, 1, 3'd7, 3'd7)));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_HLD, 1, 1, 1, 1, 3'd7, 3'd7)));
      tbl.push_back(mk(7, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_HLD, 1, 1, 1, 1, 3'd7, 3'd7)));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_MON, 1, 0, 1, 1, 3'd7, 3'd7)));
      // irq_clr alone, then irq_clr on the declaring edge (set wins)
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 3'd0, 3'd0, mk_e(S_MON, 1, 0, 1, 0, 3'd7, 3'd7)));
      tbl.push_back(mk(4, 1, 1, 0, 0, 0, 3'd0, 3'd0, mk_e(S_MON, 1, 0, 1, 0, 3'd7, 3'd7)));
      tbl.push_back(mk(1, 1, 1, 0, 1, 0, 3'd0, 3'd0, mk_e(S_BO,  1, 1, 2, 1, 3'd7, 3'd7)));
      // cnt_clr alone
      tbl.push_back(mk(1, 1, 1, 0, 0, 1, 3'd0, 3'd0, mk_e(S_BO,  1, 1, 0, 1, 3'd7, 3'd7)));
      tbl.push_back(mk(3, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_HLD, 1, 1, 0, 1, 3'd7, 3'd7)));
      tbl.push_back(mk(8, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_MON, 1, 0, 0, 1, 3'd7, 3'd7)));
      // cfg_wr in MONITOR -> SETTLE for 10 cycles
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 3'd2, 3'd5, mk_e(S_SET, 1, 0, 0, 1, 3'd2, 3'd5)));
      tbl.push_back(mk(9, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_SET, 1, 0, 0, 1, 3'd2, 3'd5)));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_MON, 1, 0, 0, 1, 3'd2, 3'd5)));
      // cfg_wr in HOLD -> trips update, state unchanged
      tbl.push_back(mk(5, 1, 1, 0, 0, 0, 3'd0, 3'd0, mk_e(S_BO,  1, 1, 1, 1, 3'd2, 3'd5)));
      tbl.push_back(mk(3, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_HLD, 1, 1, 1, 1, 3'd2, 3'd5)));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 3'd3, 3'd4, mk_e(S_HLD, 1, 1, 1, 1, 3'd3, 3'd4)));
      tbl.push_back(mk(2, 1, 0, 0, 0, 0, 3'd0, 3'd0, mk_e(S_HLD, 1, 1, 1, 1, 3'd3, 3'd4)));
      // back to BROWNOUT, then en=0 -> OFF next cycle, even with bo_out high
      tbl.push_back(mk(3, 1, 1, 0, 0, 0, 3'd0, 3'd0, mk_e(S_BO,  1, 1, 1, 1, 3'd3, 3'd4)));
      tbl.push_back(mk(1, 0, 1, 0, 0, 0, 3'd0, 3'd0, mk_e(S_OFF, 0, 0, 1, 1, 3'd3, 3'd4)));
      tbl.push_back(mk(1, 0, 1, 0, 0, 0, 3'd0, 3'd0, mk_e(S_OFF, 0, 0, 1, 1, 3'd3, 3'd4)));

      for (int i = 0; i < tbl.size(); i++) begin
         bus.en      = tbl[i].en;
         bus.bo_out  = tbl[i].bo;
         bus.cfg_wr  = tbl[i].wr;
         bus.irq_clr = tbl[i].ic;
         bus.cnt_clr = tbl[i].cc;
         bus.cfg_otrip = tbl[i].cot;
         bus.cfg_vtrip = tbl[i].cvt;
         exp_q.push_back(tbl[i].e);
         repeat (tbl[i].n) @(negedge clk);
         sb_check($sformatf("row%0d", i));
      end
      bus.cfg_wr = 1'b0; bus.irq_clr = 1'b0; bus.cnt_clr = 1'b0;

      // Re-enable; counter clear coinciding with an event, then saturation
      bus.bo_out = 1'b0;
      bus.en     = 1'b1;
      @(negedge clk);
      wait_state(S_MON, 40, "reenable.state");
      bo_event(1'b0);
      chk("evt.second", 32'(bus.evt_cnt), 32'd2);
      bo_event(1'b1);
      chk("evt.clr_with_inc", 32'(bus.evt_cnt), 32'd1);
      for (int k = 0; k < 254; k++) bo_event(1'b0);
      chk("evt.reach_255", 32'(bus.evt_cnt), 32'd255);
      bo_event(1'b0);
      chk("evt.saturate", 32'(bus.evt_cnt), 32'd255);
      chk("evt.sat_state", 32'(bus.state), 32'(S_MON));
      chk("evt.sat_sysrst", 32'(bus.sys_rst), 32'd0);

      // Asynchronous reset in the middle of HOLD
      bus.bo_out = 1'b1;
      repeat (5) @(negedge clk);
      bus.bo_out = 1'b0;
      repeat (4) @(negedge clk);
      chk("midhold.state", 32'(bus.state), 32'(S_HLD));
      #2;
      rst = 1'b1;
      #1;
      exp_q.push_back(mk_e(S_OFF, 0, 0, 0, 0, 3'd7, 3'd7));
      sb_check("async_rst");
      @(negedge clk);
      rst = 1'b0;

      // Undervoltage flag (active only when the feature is built in)
      bus.en = 1'b1;
      @(negedge clk);
      wait_state(S_MON, 40, "vun.monitor");
      bus.bo_vunder = 1'b1;
      repeat (4) @(negedge clk);
      bus.bo_vunder = 1'b0;
      repeat (2) @(negedge clk);
      chk("vun.flag", 32'(bus.vunder_flag), 32'(VUN_EN));
      chk("vun.irq", 32'(bus.irq), 32'(VUN_EN));
      chk("vun.sysrst", 32'(bus.sys_rst), 32'd0);
      chk("vun.evt", 32'(bus.evt_cnt), 32'd0);
      bus.irq_clr = 1'b1;
      @(negedge clk);
      bus.irq_clr = 1'b0;
      chk("vun.flag_clr", 32'(bus.vunder_flag), 32'd0);
      chk("vun.irq_clr", 32'(bus.irq), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/brownout_ctrl.md
Name: brownout_ctrl

Overview:
Digital-domain controller sitting on the dvdd side of the brownout detector. It drives the detector's control inputs (ena, otrip, vtrip) and consumes its asynchronous outputs (out, vunder). It sequences enable/settling, glitch-filters the brownout indication, generates a held system reset, and keeps an event counter with a sticky interrupt.

Parameters:
SETTLE_CYCLES, 1000, clk cycles after bo_ena rises (or after a trip change) during which detector outputs are ignored; minimum 1
FILT_CYCLES, 4, consecutive cycles synchronized out must be high before a brownout is declared; minimum 1
HOLD_CYCLES, 256, cycles sys_rst is held after synchronized out falls; minimum 1
CNT_W, 8, event counter width

Ports:
clk  in  1  digital clock (dvdd domain)
rst  in  1  asynchronous, active-high reset
en  in  1  software enable of the detector
cfg_otrip  in  3  requested otrip code
cfg_vtrip  in  3  requested vtrip code
cfg_wr  in  1  one-cycle strobe; latch cfg_otrip/cfg_vtrip
irq_clr  in  1  clear sticky irq
cnt_clr  in  1  clear event counter
bo_out  in  1  detector out, asynchronous
bo_vunder  in  1  detector vunder, asynchronous
bo_ena  out  1  detector ena
bo_otrip  out  3  detector otrip
bo_vtrip  out  3  detector vtrip
sys_rst  out  1  active-high system reset request
state  out  3  FSM state code
evt_cnt  out  CNT_W  brownout event count, saturating
irq  out  1  sticky brownout interrupt
vunder_flag  out  1  sticky undervoltage flag (optional feature only; otherwise tied 0)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Reset values: bo_ena=0, bo_otrip=3'b111, bo_vtrip=3'b111, sys_rst=0, state=OFF, evt_cnt=0, irq=0, vunder_flag=0. Synchronizer flops also reset to 0.
- Synchronization: bo_out and bo_vunder each pass through a 2-flop synchronizer (out_s, vun_s). Latency is 2 cycles.
- State encoding: OFF=0, SETTLE=1, MONITOR=2, BROWNOUT=3, HOLD=4. All outputs are registered.
- OFF: bo_ena=0, sys_rst=0. en=1 -> SETTLE, timer loaded with SETTLE_CYCLES.
- SETTLE: bo_ena=1. Timer decrements each cycle and out_s is ignored. Timer reaches 0 -> MONITOR. Time in SETTLE is exactly SETTLE_CYCLES cycles.
- MONITOR: the filter counter increments while out_s=1 and clears when out_s=0.
  - When the filter count reaches FILT_CYCLES -> BROWNOUT.
  - On that same edge: evt_cnt += 1 (saturating at 2^CNT_W-1) and irq is set.
- BROWNOUT: sys_rst=1. out_s=0 -> HOLD, timer loaded with HOLD_CYCLES.
- HOLD: sys_rst=1. out_s=1 -> BROWNOUT, with no new event counted and no irq. Timer reaches 0 -> MONITOR, sys_rst=0, filter counter cleared.
- en=0 in any state -> OFF next cycle. bo_ena and sys_rst fall together, and the timer and filter are cleared.
- cfg_wr: bo_otrip/bo_vtrip update on the next edge in every state.
  - In MONITOR it also forces -> SETTLE (timer reloaded).
  - In SETTLE it reloads the timer.
  - In BROWNOUT/HOLD the state is unchanged.
  - In OFF the trip codes are latched only.
- Simultaneous events:
  - irq set together with irq_clr -> irq=1 (set wins).
  - cnt_clr together with an increment -> evt_cnt=1.
  - cnt_clr alone -> 0.
  - en=0 has priority over cfg_wr and over brownout detection.
- Reset mid-operation returns everything to reset values immediately, including releasing sys_rst.

Optional Feature:
BROWNOUT_CTRL_VUNDER_EN
- Defined: in MONITOR, BROWNOUT and HOLD, vun_s=1 sets sticky vunder_flag (through the same FILT_CYCLES filter, with a separate filter counter). vunder_flag is cleared by irq_clr, with set winning. irq is additionally set on the vunder_flag rising edge. No effect on sys_rst or evt_cnt.
- Undefined: bo_vunder is unused (no synchronizer) and vunder_flag is constant 0.

Test Plan:
Parameters SETTLE_CYCLES=10, FILT_CYCLES=3, HOLD_CYCLES=8.
1. Reset, en=1, bo_out=0 -> bo_ena=1 one cycle after en is sampled; state=SETTLE for 10 cycles, then MONITOR; sys_rst=0, irq=0, evt_cnt=0.
2. In MONITOR, drive bo_out high for 2 cycles then low -> no transition, evt_cnt=0. Then drive it high for 5 cycles -> BROWNOUT 5 cycles after the rising edge (2 sync + 3 filter); sys_rst=1, evt_cnt=1, irq=1.
3. From BROWNOUT, drop bo_out -> HOLD; re-raise at hold cycle 4 -> BROWNOUT with evt_cnt still 1. Drop again -> sys_rst stays 1 for 8 HOLD cycles, then MONITOR and sys_rst=0.
4. Pulse irq_clr on the same cycle a new brownout is declared -> irq=1, evt_cnt=2. Pulse cnt_clr alone -> evt_cnt=0. Preload evt_cnt to 255 and add an event -> evt_cnt stays 255.
5. cfg_wr with cfg_otrip=3'b010, cfg_vtrip=3'b101 in MONITOR -> outputs update next edge, state=SETTLE for 10 cycles. The same write in HOLD -> outputs update, state stays HOLD.
6. en=0 during BROWNOUT -> next cycle state=OFF, bo_ena=0, sys_rst=0. Assert rst mid-HOLD -> all outputs take reset values immediately. With BROWNOUT_CTRL_VUNDER_EN defined, bo_vunder high for 4 cycles in MONITOR -> vunder_flag=1 and irq=1.
